// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg
// Shared definitions for the gate sequencer: FSM state encoding, the
// truth-table constants for the common 2-input gates (bit index = {A,B}),
// the legal settle-time range, and a helper that turns a settle time into
// the terminal count used by the settle counter.
package gate_seq_pkg;

  // Sequencer states: wait for start, hold a vector, sample it, show results
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } state_e;

  // Expected F for vectors {A,B} = 11,10,01,00 (MSB first)
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  // Legal settle time range in clock cycles
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 255;

  // Terminal count for the settle counter: it counts 0 .. S-1, so the last
  // settle cycle is S-1. Out-of-range settle times are clamped into range.
  function automatic logic [7:0] settleTerm(input int settleCycles);
    int s;
    s = settleCycles;
    if (s < SETTLE_MIN) s = SETTLE_MIN;
    if (s > SETTLE_MAX) s = SETTLE_MAX;
    return 8'(s - 1);
  endfunction

endpackage

// File: rtl/gate_sequencer_settle_counter.sv
// settle_counter
// Eight-bit cycle counter used to time how long each test vector is held on
// the gate before it is sampled.
//   clk_i   : system clock, rising edge
//   rst_i   : synchronous active-high reset, clears the count
//   clr_i   : clears the count to zero (wins over enable)
//   en_i    : advances the count by one
//   term_i  : terminal count value
//   tc_o    : high while the count equals term_i
module settle_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] term_i,
  output logic       tc_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear has priority so the sequencer can restart a vector
  // in the same cycle it would otherwise have counted
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/gate_sequencer.sv
// gate_sequencer
// Drives a 2-input combinational gate through all four input vectors
// {A,B} = 00,01,10,11, holds each for SETTLE_CYCLES cycles, samples the gate
// output for one cycle and compares it against TRUTH_TABLE. Results stay on
// the outputs until the next run.
//   TRUTH_TABLE   : expected F per vector, bit index = {A,B}
//   SETTLE_CYCLES : cycles each vector is held before sampling (1..255)
//   clk_i         : system clock, rising edge
//   rst_i         : synchronous active-high reset
//   start_i       : run request (pulse or level), honoured in IDLE/FIN only
//   gate_f_i      : output of the gate under test
//   gate_a_o      : gate input A (vector bit 1), registered
//   gate_b_o      : gate input B (vector bit 0), registered
//   busy_o        : high while a run is in progress
//   done_o        : high once a run has completed
//   pass_o        : high when done and no vector failed
//   err_mask_o    : bit i set if vector i sampled wrong
module gate_sequencer
  import gate_seq_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_AND,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       gate_f_i,
  output logic       gate_a_o,
  output logic       gate_b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] err_mask_o
);

  localparam logic [7:0] SETTLE_TERM = settleTerm(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] errMask_q, errMask_d;
  logic [1:0] gate_q, gate_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic cntClr;
  logic cntEn;
  logic cntTc;

  settle_counter u_settle_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cntClr),
    .en_i   (cntEn),
    .term_i (SETTLE_TERM),
    .tc_o   (cntTc)
  );

  // Next-state logic. The outputs are derived from the next state so that
  // the gate inputs, BUSY and DONE all come straight from flops and change
  // on the same edge as the state itself.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    errMask_d = errMask_q;
    cntClr    = 1'b0;
    cntEn     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start_i) begin
          state_d   = ST_SETTLE;
          idx_d     = 2'd0;
          errMask_d = 4'b0000;
          cntClr    = 1'b1;
        end
      end
      ST_SETTLE: begin
        cntEn = 1'b1;
        if (cntTc) begin
          state_d = ST_SAMPLE;
          cntClr  = 1'b1;
        end
      end
      ST_SAMPLE: begin
        cntClr = 1'b1;
        if (gate_f_i != TRUTH_TABLE[idx_q]) begin
          errMask_d[idx_q] = 1'b1;
        end
        // The last vector ends the run instead of wrapping idx
        if (idx_q == 2'd3) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_FIN);
    gate_d = busy_d ? idx_d : 2'b00;
  end

  // State, vector index, results and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      errMask_q <= 4'b0000;
      gate_q    <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      errMask_q <= errMask_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign gate_a_o   = gate_q[1];
  assign gate_b_o   = gate_q[0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = done_q && (errMask_q == 4'b0000);
  assign err_mask_o = errMask_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// tb_gate_sequencer
// Bench for gate_sequencer. Four instances cover the parameter sets needed:
//   dut0 : S=2,   TT_AND, gate behaviour selectable (AND/OR/const1/const0)
//   dut1 : S=1,   TT_OR,  OR gate attached
//   dut2 : S=1,   TT_AND, OR gate attached (expected to flag vectors 1,2)
//   dut3 : S=255, TT_AND, AND gate attached
// The stimulus queues the expected result of each run; the monitor retires
// it when DONE rises, also checking the BUSY length and the {A,B} sequence.
module tb_gate_sequencer;
  import gate_seq_pkg::*;

  localparam int NDUT = 4;

  typedef struct {
    logic [3:0] mask;
    logic       pass;
    int         s;
  } want_t;

  logic       clk;
  logic       rst;
  logic       startA [NDUT];
  logic       gA     [NDUT];
  logic       gB     [NDUT];
  logic       gF     [NDUT];
  logic       busyA  [NDUT];
  logic       doneA  [NDUT];
  logic       passA  [NDUT];
  logic [3:0] maskA  [NDUT];
  int         modeA  [NDUT];

  want_t sb [NDUT][$];
  int    busyRun  [NDUT];
  int    abErr    [NDUT];
  logic  donePrev [NDUT];

  int total;
  int bad;

  // Settle time of each instance
  function automatic int sOf(input int i);
    case (i)
      0:       return 2;
      3:       return 255;
      default: return 1;
    endcase
  endfunction

  // Truth table each instance is built with
  function automatic logic [3:0] ttOf(input int i);
    return (i == 1) ? TT_OR : TT_AND;
  endfunction

  // Behaviour of the attached gate: 0 AND, 1 OR, 2 stuck at 1, 3 stuck at 0
  function automatic logic gateModel(input int m, input logic a, input logic b);
    case (m)
      0:       return a & b;
      1:       return a | b;
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 100 MHz style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One sequencer plus its gate model per parameter set
  for (genvar gi = 0; gi < NDUT; gi++) begin : g
    assign gF[gi] = gateModel(modeA[gi], gA[gi], gB[gi]);

    gate_sequencer #(
      .TRUTH_TABLE   (ttOf(gi)),
      .SETTLE_CYCLES (sOf(gi))
    ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (startA[gi]),
      .gate_f_i   (gF[gi]),
      .gate_a_o   (gA[gi]),
      .gate_b_o   (gB[gi]),
      .busy_o     (busyA[gi]),
      .done_o     (doneA[gi]),
      .pass_o     (passA[gi]),
      .err_mask_o (maskA[gi])
    );
  end

  // Single comparison point: counts it and reports a failure line
  task automatic checkOutput(input string name, input int id,
                             input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s dut%0d actual=%0h required=%0h", name, id, act, want);
    end
  endtask

  // Issue a START pulse to one instance and queue its expected result;
  // the cycle after the start edge it must be busy with DONE already low
  task automatic applyStimulus(input int id, input logic [3:0] mask);
    @(negedge clk);
    startA[id] = 1'b1;
    sb[id].push_back('{mask: mask, pass: (mask == 4'b0000), s: sOf(id)});
    @(negedge clk);
    startA[id] = 1'b0;
    checkOutput("startAck", id, 32'({busyA[id], doneA[id]}), 32'b10);
  endtask

  // Wait, within a cycle budget, for the monitor to retire the queued run
  task automatic waitResult(input int id, input int budget);
    int n;
    n = 0;
    while (sb[id].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb[id].size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL doneTimeout dut%0d actual=no DONE after %0d cycles required=DONE", id, budget);
      sb[id].delete();
    end
  endtask

  // Monitor: follows every instance each cycle away from the active edge.
  // While busy, {A,B} must equal the vector implied by the cycle position
  // in the run; when idle it must be 00. On DONE rising, the run's mask,
  // pass flag, busy length and vector sequence are compared to the queue.
  always @(negedge clk) begin
    want_t w;
    for (int i = 0; i < NDUT; i++) begin
      if (busyA[i]) begin
        if (sb[i].size() == 0) begin
          if (busyRun[i] == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL busyWithoutStart dut%0d actual=busy required=idle", i);
          end
        end else if ({gA[i], gB[i]} != 2'(busyRun[i] / (sb[i][0].s + 1))) begin
          abErr[i]++;
        end
        busyRun[i]++;
      end else begin
        if ({gA[i], gB[i]} != 2'b00) abErr[i]++;
        if (doneA[i] && !donePrev[i]) begin
          if (sb[i].size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL doneWithoutRun dut%0d actual=done required=idle", i);
          end else begin
            w = sb[i].pop_front();
            checkOutput("errMask",      i, 32'(maskA[i]), 32'(w.mask));
            checkOutput("pass",         i, 32'(passA[i]), 32'(w.pass));
            checkOutput("busyCycles",   i, 32'(busyRun[i]), 32'(4 * (w.s + 1)));
            checkOutput("gateSequence", i, 32'(abErr[i]), 32'd0);
          end
          abErr[i] = 0;
        end else if (busyRun[i] != 0) begin
          abErr[i] = 0;
        end
        busyRun[i] = 0;
      end
      donePrev[i] = doneA[i];
    end
  end

  // Directed test sequence
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      startA[i]   = 1'b0;
      busyRun[i]  = 0;
      abErr[i]    = 0;
      donePrev[i] = 1'b0;
    end
    modeA[0] = 0;
    modeA[1] = 1;
    modeA[2] = 1;
    modeA[3] = 0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      checkOutput("resetState", i,
                  32'({busyA[i], doneA[i], passA[i], maskA[i], gA[i], gB[i]}), 32'd0);
    end
    repeat (4) @(negedge clk);

    $display("[TB] AND gate, TT_AND, S=2");
    applyStimulus(0, 4'b0000);
    waitResult(0, 40);

    $display("[TB] F stuck at 1, restart from FIN");
    modeA[0] = 2;
    applyStimulus(0, 4'b0111);
    waitResult(0, 40);

    $display("[TB] F stuck at 0");
    modeA[0] = 3;
    applyStimulus(0, 4'b1000);
    waitResult(0, 40);

    $display("[TB] START repeated while busy is ignored");
    modeA[0] = 0;
    applyStimulus(0, 4'b0000);
    repeat (3) @(negedge clk);
    startA[0] = 1'b1;
    @(negedge clk);
    startA[0] = 1'b0;
    waitResult(0, 40);

    $display("[TB] OR gate with TT_OR and with TT_AND, S=1");
    applyStimulus(1, 4'b0000);
    waitResult(1, 30);
    applyStimulus(2, 4'b0110);
    waitResult(2, 30);

    $display("[TB] reset mid-run");
    modeA[0] = 2;
    applyStimulus(0, 4'b0111);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb[0].delete();
    checkOutput("rstMidRun", 0,
                32'({busyA[0], doneA[0], passA[0], maskA[0], gA[0], gB[0]}), 32'd0);
    modeA[0] = 0;
    applyStimulus(0, 4'b0000);
    waitResult(0, 40);

    $display("[TB] START together with RST");
    @(negedge clk);
    rst       = 1'b1;
    startA[0] = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    startA[0] = 1'b0;
    checkOutput("startUnderReset", 0, 32'({busyA[0], doneA[0], maskA[0]}), 32'd0);
    @(negedge clk);
    checkOutput("stillIdle", 0, 32'({busyA[0], doneA[0], gA[0], gB[0]}), 32'd0);

    $display("[TB] AND gate, TT_AND, S=255");
    applyStimulus(3, 4'b0000);
    waitResult(3, 1200);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
